// File: rtl/pc_addr_unit.sv
// pc_addr_unit: program counter and memory-address stage behind the CPU
// control FSM. Holds the PC and the data-address register, resolves
// branches/calls/returns against the status flags, and drives the single
// memory address bus.
//
// Ports:
//   clk            system clock, rising-edge
//   reset          asynchronous active-low reset
//   load_pc        PC update strobe for this edge
//   reset_pc       with load_pc: load RESET_VECTOR (highest priority)
//   trigger_branch with load_pc: resolve branch/call/return
//   addr_sel       1: mem_addr = pc, 0: mem_addr = data_addr
//   load_addr      capture datapath_out into data_addr
//   opcode/op/cond instruction fields from IR
//   sximm8         sign-extended 8-bit immediate (relative offset)
//   datapath_out   datapath C register (data address, BX/BLX target)
//   Z, N, V        status flags
//   pc             current PC register
//   return_addr    zero-extended pc, written to R7 by BL/BLX
//   mem_addr       memory address bus (combinational mux)
//   branch_taken   one-cycle pulse after a taken branch/call/return
//   bad_branch     one-cycle pulse after an undecodable branch encoding
module pc_addr_unit #(
  parameter int unsigned             PC_WIDTH     = 9,
  parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_pc,
  input  logic                reset_pc,
  input  logic                trigger_branch,
  input  logic                addr_sel,
  input  logic                load_addr,
  input  logic [2:0]          opcode,
  input  logic [1:0]          op,
  input  logic [2:0]          cond,
  input  logic [15:0]         sximm8,
  input  logic [15:0]         datapath_out,
  input  logic                Z,
  input  logic                N,
  input  logic                V,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         return_addr,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                branch_taken,
  output logic                bad_branch
);

  // Outcome of decoding the branch fields for the current instruction.
  typedef enum logic [1:0] {
    DEC_HOLD,   // valid conditional branch, not taken
    DEC_REL,    // taken, PC-relative target
    DEC_ABS,    // taken, register target (BX/BLX)
    DEC_BAD     // undecodable encoding
  } dec_e;

  dec_e                dec;
  logic                cond_true;
  logic [PC_WIDTH-1:0] data_addr;
  logic [PC_WIDTH-1:0] rel_target;
  logic [PC_WIDTH-1:0] abs_target;
  logic                unused_hi_bits;

  // Targets truncate to PC_WIDTH, so relative branches wrap naturally.
  assign rel_target = pc + sximm8[PC_WIDTH-1:0];
  assign abs_target = datapath_out[PC_WIDTH-1:0];
  assign unused_hi_bits = ^{sximm8[15:PC_WIDTH], datapath_out[15:PC_WIDTH]};

  always_comb begin
    cond_true = 1'b0;
    dec       = DEC_BAD;
    unique case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = Z;
      3'b010:  cond_true = ~Z;
      3'b011:  cond_true = N ^ V;
      3'b100:  cond_true = (N ^ V) | Z;
      default: cond_true = 1'b0;
    endcase

    if (opcode == 3'b001 && op == 2'b00) begin
      if (cond > 3'b100)  dec = DEC_BAD;
      else if (cond_true) dec = DEC_REL;
      else                dec = DEC_HOLD;
    end else if (opcode == 3'b010 && op == 2'b11) begin
      dec = DEC_REL;
    end else if (opcode == 3'b010 && (op == 2'b00 || op == 2'b10)) begin
      dec = DEC_ABS;
    end else begin
      dec = DEC_BAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_VECTOR;
      data_addr    <= '0;
      branch_taken <= 1'b0;
      bad_branch   <= 1'b0;
    end else begin
      branch_taken <= 1'b0;
      bad_branch   <= 1'b0;

      if (load_pc) begin
        if (reset_pc) begin
          pc <= RESET_VECTOR;
        end else if (trigger_branch) begin
          unique case (dec)
            DEC_REL: begin
              pc           <= rel_target;
              branch_taken <= 1'b1;
            end
            DEC_ABS: begin
              pc           <= abs_target;
              branch_taken <= 1'b1;
            end
            DEC_BAD:  bad_branch <= 1'b1;
            default:  ;  // not taken: PC already points past the branch
          endcase
        end else begin
          pc <= pc + PC_WIDTH'(1);
        end
      end

      if (load_addr)
        data_addr <= datapath_out[PC_WIDTH-1:0];
    end
  end

  assign mem_addr    = addr_sel ? pc : data_addr;
  assign return_addr = 16'(pc);

endmodule

// File: tb/tb_pc_addr_unit.sv
module tb_pc_addr_unit;
  localparam int W    = 9;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_pc = 1'b0, reset_pc = 1'b0, trigger_branch = 1'b0;
  logic          addr_sel = 1'b1, load_addr = 1'b0;
  logic [2:0]    opcode = '0, cond = '0;
  logic [1:0]    op = '0;
  logic [15:0]   sximm8 = '0, datapath_out = '0;
  logic          Z = 1'b0, N = 1'b0, V = 1'b0;
  logic [W-1:0]  pc, mem_addr;
  logic [15:0]   return_addr;
  logic          branch_taken, bad_branch;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  pc_addr_unit #(.PC_WIDTH(W), .RESET_VECTOR('0)) dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .reset_pc(reset_pc),
    .trigger_branch(trigger_branch), .addr_sel(addr_sel), .load_addr(load_addr),
    .opcode(opcode), .op(op), .cond(cond), .sximm8(sximm8),
    .datapath_out(datapath_out), .Z(Z), .N(N), .V(V), .pc(pc),
    .return_addr(return_addr), .mem_addr(mem_addr),
    .branch_taken(branch_taken), .bad_branch(bad_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain integers.
  int m_pc = 0, m_da = 0, m_bt = 0, m_bb = 0;

  always @(posedge clk or negedge reset) begin
    int npc, bt, bb, t;
    if (!reset) begin
      m_pc = 0; m_da = 0; m_bt = 0; m_bb = 0;
    end else begin
      npc = m_pc; bt = 0; bb = 0; t = 0;
      if (load_pc) begin
        if (reset_pc) npc = 0;
        else if (trigger_branch) begin
          if (opcode == 1 && op == 0) begin
            case (cond)
              0: t = 1;
              1: t = Z;
              2: t = !Z;
              3: t = (N != V);
              4: t = (N != V) || Z;
              default: t = -1;
            endcase
            if (t < 0) bb = 1;
            else if (t == 1) begin
              npc = (m_pc + int'($signed(sximm8))) & MASK;
              bt = 1;
            end
          end else if (opcode == 2 && op == 3) begin
            npc = (m_pc + int'($signed(sximm8))) & MASK;
            bt = 1;
          end else if (opcode == 2 && (op == 0 || op == 2)) begin
            npc = int'(datapath_out) & MASK;
            bt = 1;
          end else bb = 1;
        end else npc = (m_pc + 1) & MASK;
      end
      if (load_addr) m_da = int'(datapath_out) & MASK;
      m_pc = npc; m_bt = bt; m_bb = bb;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("mem_addr", 32'(mem_addr), 32'(addr_sel ? m_pc : m_da));
      chk("return_addr", 32'(return_addr), 32'(m_pc));
      chk("branch_taken", 32'(branch_taken), 32'(m_bt));
      chk("bad_branch", 32'(bad_branch), 32'(m_bb));
      chk("excl_flags", 32'(branch_taken & bad_branch), 32'd0);
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    load_pc = 0; reset_pc = 0; trigger_branch = 0; load_addr = 0;
  endtask

  task automatic br(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                    input logic [15:0] sx, input logic [15:0] dp);
    load_pc = 1; reset_pc = 0; trigger_branch = 1; load_addr = 0;
    opcode = opc; op = o; cond = c; sximm8 = sx; datapath_out = dp;
  endtask

  task automatic pin_pc(input string name, input int exp);
    chk(name, 32'(pc), 32'(exp));
    chk({name, "_model"}, 32'(m_pc), 32'(exp));
  endtask

  initial begin
    #1 reset = 0;
    #3;
    pin_pc("reset_pc", 0);
    chk("reset_bt", 32'(branch_taken), 0);
    chk("reset_bb", 32'(bad_branch), 0);
    reset = 1;
    check_en = 1;
    cyc();

    // Increment from reset
    load_pc = 1;
    cyc(); pin_pc("inc1", 1);
    cyc(); pin_pc("inc2", 2);
    cyc(); pin_pc("inc3", 3);
    chk("inc_bt", 32'(branch_taken), 0);

    // BEQ taken/not taken, BLE
    br(3'd2, 2'd0, 3'd0, 16'h0, 16'h0010); cyc(); pin_pc("bx_0x10", 'h10);
    br(3'd1, 2'd0, 3'd1, 16'hFFFC, 16'h0); Z = 1; cyc();
    pin_pc("beq_taken", 'h00C);
    chk("beq_bt", 32'(branch_taken), 1);
    idle(); cyc();
    chk("beq_bt_clear", 32'(branch_taken), 0);
    br(3'd2, 2'd0, 3'd0, 16'h0, 16'h0010); cyc();
    br(3'd1, 2'd0, 3'd1, 16'hFFFC, 16'h0); Z = 0; cyc();
    pin_pc("beq_not_taken", 'h010);
    chk("beq_nt_bt", 32'(branch_taken), 0);
    br(3'd1, 2'd0, 3'd4, 16'h0004, 16'h0); N = 1; V = 0; Z = 0; cyc();
    pin_pc("ble_taken", 'h014);
    N = 0;

    // Wrap-around
    br(3'd2, 2'd0, 3'd0, 16'h0, 16'h01FF); cyc();
    idle(); load_pc = 1; cyc(); pin_pc("wrap_inc", 0);
    br(3'd2, 2'd0, 3'd0, 16'h0, 16'h0002); cyc();
    br(3'd1, 2'd0, 3'd0, 16'hFFF0, 16'h0); cyc(); pin_pc("wrap_neg", 'h1F2);

    // BX / BL
    br(3'd2, 2'd0, 3'd0, 16'h0, 16'hABCD); cyc(); pin_pc("bx_abcd", 'h1CD);
    br(3'd2, 2'd2, 3'd0, 16'h0, 16'h0020); cyc(); pin_pc("blx_0x20", 'h020);
    br(3'd2, 2'd3, 3'd0, 16'h0005, 16'h0);
    chk("ret_addr_before", 32'(return_addr), 'h0020);
    cyc(); pin_pc("bl_rel", 'h025);

    // Address mux
    idle(); load_addr = 1; datapath_out = 16'h0123; cyc();
    idle(); addr_sel = 0; #1 chk("mux_data", 32'(mem_addr), 'h123);
    addr_sel = 1; #1 chk("mux_pc", 32'(mem_addr), 'h025);

    // Bad branches
    br(3'd1, 2'd0, 3'd6, 16'h0, 16'h0); cyc();
    pin_pc("bad_cond_hold", 'h025);
    chk("bad_cond_bb", 32'(bad_branch), 1);
    idle(); cyc();
    chk("bad_bb_clear", 32'(bad_branch), 0);
    br(3'd3, 2'd1, 3'd0, 16'h0, 16'h0); cyc();
    chk("bad_opcode_bb", 32'(bad_branch), 1);

    // Priority: reset_pc wins
    br(3'd2, 2'd0, 3'd0, 16'h0, 16'h0077); reset_pc = 1; cyc();
    pin_pc("prio_reset_pc", 0);

    // Async reset mid-cycle
    br(3'd2, 2'd0, 3'd0, 16'h0, 16'h0055); cyc(); pin_pc("pre_async", 'h55);
    idle();
    @(posedge clk); #2 reset = 0;
    #1 pin_pc("async_reset", 0);
    reset = 1;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      load_pc        = ($urandom_range(0, 3) != 0);
      reset_pc       = ($urandom_range(0, 19) == 0);
      trigger_branch = ($urandom_range(0, 9) < 4);
      load_addr      = ($urandom_range(0, 3) == 0);
      addr_sel       = 1'($urandom_range(0, 1));
      opcode         = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 2)) : 3'($urandom);
      op             = 2'($urandom);
      cond           = 3'($urandom);
      sximm8         = 16'($signed(8'($urandom)));
      datapath_out   = 16'($urandom);
      Z = 1'($urandom); N = 1'($urandom); V = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset = 0; #1 reset = 1;
      end
      cyc();
    end

    idle();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
